// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: requester start/done handshake plus the link to the shared full-adder cell
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic start, cin, busy, done, cout;
  logic fa_a, fa_b, fa_c, fa_s, fa_cout;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output start, a, b, cin, fa_s, fa_cout,
    input busy, done, sum, cout, fa_a, fa_b, fa_c
  );
  modport slave (
    input start, a, b, cin, fa_s, fa_cout,
    output busy, done, sum, cout, fa_a, fa_b, fa_c
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer feeding one operand bit pair per clock to an external full adder
module serial_add_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_cout;
  logic w_run;
  assign w_run = r_state == RUN;
  assign bus.fa_a = w_run & r_a[0];
  assign bus.fa_b = w_run & r_b[0];
  assign bus.fa_c = w_run & r_carry;
  assign bus.busy = w_run;
  assign bus.done = r_state == DONE;
  assign bus.sum = r_sum;
  assign bus.cout = r_cout;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_a <= bus.a;
        r_b <= bus.b;
        r_carry <= bus.cin;
        r_cnt <= '0;
        r_state <= RUN;
      end
    end else if (w_run) begin
      r_sum <= (r_sum >> 1) | (WIDTH'(bus.fa_s) << (WIDTH - 1));
      r_carry <= bus.fa_cout;
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_cout <= bus.fa_cout;
        r_state <= DONE;
      end
    end else
      r_state <= IDLE;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for WIDTH=8 directed adds and WIDTH=1 exhaustive back-to-back adds
module tb_serial_add_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, errs = 0, dc8 = 0, dc1 = 0, cyc = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  serial_add_ctrl_if #(.WIDTH(8)) b8();
  serial_add_ctrl_if #(.WIDTH(1)) b1();
  serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
  serial_add_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  assign b8.fa_s = b8.busy ? b8.fa_a ^ b8.fa_b ^ b8.fa_c : 1'bx;
  assign b8.fa_cout = b8.busy ? (b8.fa_a & b8.fa_b) | (b8.fa_c & (b8.fa_a ^ b8.fa_b)) : 1'bx;
  assign b1.fa_s = b1.busy ? b1.fa_a ^ b1.fa_b ^ b1.fa_c : 1'bx;
  assign b1.fa_cout = b1.busy ? (b1.fa_a & b1.fa_b) | (b1.fa_c & (b1.fa_a ^ b1.fa_b)) : 1'bx;
  always @(posedge clk) begin
    dc8 <= dc8 + int'(b8.done);
    dc1 <= dc1 + int'(b1.done);
    cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit push);
    b8.a = a;
    b8.b = b;
    b8.cin = cin;
    b8.start = 1'b1;
    if (push) q8.push_back(9'(a) + 9'(b) + 9'(cin));
    @(negedge clk);
    b8.start = 1'b0;
  endtask
  task automatic wait_done8(input string tag, input int exp_busy);
    int nb = 0, t = 0;
    logic [8:0] e;
    while (b8.done !== 1'b1 && t < 40) begin
      nb += int'(b8.busy);
      t++;
      @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'(t < 40), 1);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_busy_at_done"}, b8.busy, 0);
    e = q8.size() != 0 ? q8.pop_front() : 'x;
    chk({tag, "_sum"}, b8.sum, e[7:0]);
    chk({tag, "_cout"}, b8.cout, e[8]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, b8.done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, t, last;
    logic [2:0] v;
    logic [1:0] e1;
    last = 0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_sum", b8.sum, 0);
    chk("rst_cout", b8.cout, 0);
    chk("rst_fa", {b8.fa_a, b8.fa_b, b8.fa_c}, 0);
    rst = 1'b0;
    @(negedge clk);
    start8(8'h03, 8'h05, 1'b0, 1'b1);
    chk("run_fa_bits", {b8.fa_a, b8.fa_b, b8.fa_c}, 3'b110);
    wait_done8("add_3_5", 8);
    repeat (3) @(negedge clk);
    chk("hold_sum", b8.sum, 8'h08);
    start8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8("ff_01", 8);
    chk("idle_fa_c_gated", b8.fa_c, 0);
    start8(8'hFF, 8'hFF, 1'b1, 1'b1);
    wait_done8("ff_ff_1", 8);
    for (int i = 0; i < 4; i++) begin
      start8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_done8("rand", 8);
    end
    d0 = dc8;
    start8(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    b8.a = 8'hAA;
    b8.b = 8'h55;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    wait_done8("busy_prot", 5);
    repeat (4) @(negedge clk);
    chk("busy_prot_done_count", dc8 - d0, 1);
    chk("busy_prot_hold", b8.sum, 8'h30);
    d0 = dc8;
    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", b8.busy, 0);
    chk("abort_done", b8.done, 0);
    chk("abort_sum", b8.sum, 0);
    chk("abort_cout", b8.cout, 0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", dc8 - d0, 0);
    start8(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done8("after_abort", 8);
    b1.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      b1.a = v[2];
      b1.b = v[1];
      b1.cin = v[0];
      q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (b1.busy !== 1'b1 && t < 10);
      chk("w1_accept_timeout", 32'(t < 10), 1);
      if (i > 0) chk("w1_accept_interval", cyc - last, 3);
      last = cyc;
      @(negedge clk);
      chk("w1_done", b1.done, 1);
      e1 = q1.size() != 0 ? q1.pop_front() : 'x;
      chk("w1_result", {b1.cout, b1.sum}, e1);
    end
    b1.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("w1_done_count", dc1, 8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
